// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory adapters.
//   - store opcode encodings (st_op)
//   - store adapter FSM state type
//   - lane / byte width constants
//   - st_is_err(): request rejection rule shared by the store path
package mem_pkg;

    localparam int BYTE_W    = 8;
    localparam int HALF_W    = 16;
    localparam int WORD_W    = 32;
    localparam int NUM_LANES = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        RWAIT = 2'd2,
        WRITE = 2'd3
    } state_e;

    // Reserved opcode is always rejected; alignment only when checking is on.
    function automatic logic st_is_err(input logic [1:0] op,
                                       input logic [1:0] lane,
                                       input logic       chk_align);
        logic e;
        e = (op == ST_RSV);
        if (chk_align) begin
            if (op == ST_SW && lane != 2'b00) e = 1'b1;
            if (op == ST_SH && lane[0])       e = 1'b1;
        end
        return e;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational little-endian lane merge for sub-word stores.
// Ports:
//   op     in  store opcode (sw/sh/sb; reserved keeps the old word)
//   lane   in  addr[1:0] of the store
//   data   in  register data (low byte/half used for sb/sh)
//   old    in  word currently in memory
//   merged out old word with the addressed lane(s) replaced
module store_merge
    import mem_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] data,
    input  logic [WORD_W-1:0] old,
    output logic [WORD_W-1:0] merged
);

    logic [NUM_LANES-1:0][BYTE_W-1:0] d, o, m;

    assign d      = data;
    assign o      = old;
    assign merged = m;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [1:0] LN = 2'(g);
        logic              sel;
        logic [BYTE_W-1:0] src;

        // sh sources byte 0/1 of the register for the low/high byte of
        // the selected half; sb always sources byte 0.
        always_comb begin
            sel = 1'b0;
            src = d[g];
            case (op)
                ST_SW: begin sel = 1'b1;               src = d[g];              end
                ST_SH: begin sel = (lane[1] == LN[1]); src = d[{1'b0, LN[0]}];  end
                ST_SB: begin sel = (lane == LN);       src = d[0];              end
                default: begin sel = 1'b0;             src = d[g];              end
            endcase
        end

        assign m[g] = sel ? src : o[g];
    end

endmodule

// File: rtl/mem_store_rmw.sv
// Store-side adapter: turns sw/sh/sb into word-only memory accesses.
// Word stores are written directly; sub-word stores read the word, merge
// the new lane(s) and write it back.
// Ports:
//   clk, reset                      clock, async active-low reset
//   st_valid/st_ready               store request handshake
//   st_op, st_addr, st_data         store request payload
//   st_done                         one-cycle pulse, store committed
//   st_err                          one-cycle pulse, request rejected
//   mem_req/mem_gnt                 memory request, held until granted
//   mem_we, mem_addr, mem_wdata     request payload (word address)
//   mem_rvalid, mem_rdata           read return
module mem_store_rmw
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_op,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [WORD_W-1:0] st_data,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   data_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   merged;
    logic                done_q, err_q;
    logic                accept, req_err;

    assign accept  = st_valid && st_ready;
    assign req_err = st_is_err(st_op, st_addr[1:0], CHECK_ALIGN);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !req_err)
                         state_d = (st_op == ST_SW) ? WRITE : READ;
            READ:    if (mem_gnt)    state_d = RWAIT;
            RWAIT:   if (mem_rvalid) state_d = WRITE;
            WRITE:   if (mem_gnt)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state so a reset drops mem_req immediately.
    always_comb begin
        st_ready = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE:    st_ready = 1'b1;
            READ:    mem_req  = 1'b1;
            WRITE:   begin mem_req = 1'b1; mem_we = 1'b1; end
            default: ;
        endcase
    end

    store_merge u_merge (
        .op     (op_q),
        .lane   (addr_q[1:0]),
        .data   (data_q),
        .old    (mem_rdata),
        .merged (merged)
    );

    // Capture, write-data and completion pulses. wdata_q only changes in
    // IDLE and RWAIT, so it is stable whenever a write is pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= ST_SW;
            addr_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= (state_q == WRITE) && mem_gnt;
            err_q  <= accept && req_err;
            if (accept && !req_err) begin
                op_q   <= st_op;
                addr_q <= st_addr;
                data_q <= st_data;
                if (st_op == ST_SW) wdata_q <= st_data;
            end
            if (state_q == RWAIT && mem_rvalid) wdata_q <= merged;
        end
    end

    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_wdata = wdata_q;
    assign st_done   = done_q;
    assign st_err    = err_q;

endmodule
